// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction fetch unit.
package ifu_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } ifu_state_t;

  localparam int unsigned INSTR_BYTES = 4;

  // Counters must reach FIFO_DEPTH itself, hence one bit more than the pointer.
  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/ifu_fifo.sv
// Prefetch FIFO holding {pc, data} entries; flush empties it and wins over push/pop.
module ifu_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_data;
  end

  assign head_data = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/instr_fetch_unit.sv
// Sequential instruction prefetcher: credit-limited imem requests, in-order
// responses into a prefetch FIFO, and redirect with discard of in-flight reads.
//
// state | meaning
// IDLE  | one cycle after reset release, no requests
// RUN   | issue while credits remain, push responses into the FIFO
// FLUSH | after redirect, drop responses until discard_cnt reaches 0
module instr_fetch_unit
  import ifu_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr_data,
  output logic [31:0] instr_pc
);

  localparam int          CW   = cnt_width(FIFO_DEPTH);
  localparam logic [31:0] STEP = 32'(INSTR_BYTES);

  ifu_state_t  state;
  logic [31:0] fetch_pc;
  logic [31:0] resp_pc;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] discard_cnt;
  logic [CW-1:0] out_next;
  logic [CW-1:0] fifo_count;
  logic [CW:0]   credit_used;
  logic          issue;
  logic          resp;
  logic          fifo_push;
  logic          fifo_pop;
  logic          fifo_full;
  logic          fifo_empty;
  logic [63:0]   fifo_head;
  logic [31:0]   redirect_base;
  logic          unused_pc_bits;

  assign unused_pc_bits = &{1'b0, redirect_pc[1:0]};
  assign redirect_base  = {redirect_pc[31:2], 2'b00};

  // Every outstanding read owns a FIFO slot, so responses can never overflow.
  assign credit_used = {1'b0, outstanding} + {1'b0, fifo_count};
  assign imem_req    = (state == RUN) && (credit_used < (CW+1)'(FIFO_DEPTH));
  assign imem_addr   = fetch_pc;

  assign issue    = imem_req && imem_gnt;
  assign resp     = imem_rvalid && (outstanding != '0);
  assign out_next = outstanding + CW'(issue) - CW'(resp);

  assign fifo_push = resp && (state == RUN) && !redirect;
  assign fifo_pop  = instr_valid && instr_ready && !redirect;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
      discard_cnt <= '0;
    end else if (redirect) begin
      fetch_pc    <= redirect_base;
      resp_pc     <= redirect_base;
      outstanding <= out_next;
      discard_cnt <= out_next;
      state       <= (out_next != '0) ? FLUSH : RUN;
    end else begin
      outstanding <= out_next;
      if (issue) fetch_pc <= fetch_pc + STEP;
      case (state)
        IDLE: state <= RUN;
        RUN: begin
          if (resp) resp_pc <= resp_pc + STEP;
        end
        FLUSH: begin
          if (resp) begin
            discard_cnt <= discard_cnt - CW'(1);
            if (discard_cnt == CW'(1)) state <= RUN;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset_n && fifo_push) assert (!fifo_full || fifo_pop);
  end

  ifu_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (64),
    .CW    (CW)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .flush     (redirect),
    .push      (fifo_push),
    .push_data ({resp_pc, imem_rdata}),
    .pop       (fifo_pop),
    .head_data (fifo_head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign instr_valid = !fifo_empty;
  assign instr_pc    = fifo_head[63:32];
  assign instr_data  = fifo_head[31:0];

endmodule
